// File: rtl/param_ram_pkg.sv
// param_ram_pkg
//   Shared types and elaboration helpers for the parametrised scratch RAM.
//   - state_t       : controller state encoding (IDLE / CLEAR)
//   - be_width()    : number of byte lanes for a given word width
//   - word_size_ok(): legality of a word width (non-zero multiple of 8)
package param_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int be_width(input int word_size);
    return word_size / 8;
  endfunction

  function automatic bit word_size_ok(input int word_size);
    return (word_size > 0) && ((word_size % 8) == 0);
  endfunction

endpackage

// File: rtl/param_ram_if.sv
// param_ram_if
//   Bus between a simple master (CPU/DMA stub) and param_ram.
//   master drives : clr, req, we, addr, wdata, be
//   slave drives  : ready, rdata, rvalid, busy
interface param_ram_if
  import param_ram_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 32
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = be_width(WORD_SIZE);

  logic                 clr;
  logic                 req;
  logic                 we;
  logic [ADDR_W-1:0]    addr;
  logic [WORD_SIZE-1:0] wdata;
  logic [BE_W-1:0]      be;
  logic                 ready;
  logic [WORD_SIZE-1:0] rdata;
  logic                 rvalid;
  logic                 busy;

  modport master (
    output clr, req, we, addr, wdata, be,
    input  ready, rdata, rvalid, busy
  );

  modport slave (
    input  clr, req, we, addr, wdata, be,
    output ready, rdata, rvalid, busy
  );

endinterface

// File: rtl/param_ram_array.sv
// param_ram_array
//   Storage for param_ram: one write port with byte enables and one
//   synchronous read port sharing a single address.
//   clk, rst_n : clock, async active-low reset (read register only)
//   i_we       : write strobe; bytes with i_be set are written
//   i_re       : read strobe; o_rdata updates on the following edge
//   i_addr     : word address; addresses >= DEPTH are masked
//   i_wdata    : write data
//   i_be       : byte enables, i_be[i] covers i_wdata[8i+7:8i]
//   o_rdata    : registered read data, held between reads
module param_ram_array
  import param_ram_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int DEPTH     = 32,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int BE_W      = be_width(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  input  logic [BE_W-1:0]      i_be,
  output logic [WORD_SIZE-1:0] o_rdata
);

  logic [WORD_SIZE-1:0] r_mem [DEPTH];
  logic [WORD_SIZE-1:0] r_rdata;
  logic                 w_in_range;

  // DEPTH need not be a power of two, so the top of the address space may
  // point past the array.
  assign w_in_range = ({1'b0, i_addr} < (ADDR_W + 1)'(DEPTH));

  // Array itself is never reset; contents are defined only by writes/clear.
  always_ff @(posedge clk) begin
    if (i_we && w_in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read samples the array before any same-edge write lands, so a read
  // followed by a write to the same address returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_in_range ? r_mem[i_addr] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/param_ram.sv
// param_ram
//   Parametrised single-port synchronous RAM with byte enables, req/ready
//   handshake, optional output register and a zero-fill clear sequencer.
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : param_ram_if slave (clr, req, we, addr, wdata, be /
//           ready, rdata, rvalid, busy)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | ready = 1, busy = 0; accepts req, clr starts a clear
//   ST_CLEAR | ready = 0, busy = 1; writes 0 to mem[cnt], cnt 0..DEPTH-1
module param_ram
  import param_ram_pkg::*;
#(
  parameter int WORD_SIZE      = 8,
  parameter int DEPTH          = 32,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  param_ram_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = be_width(WORD_SIZE);

  localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (!word_size_ok(WORD_SIZE)) begin : g_bad_word_size
    $error("param_ram: WORD_SIZE must be a non-zero multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_ram: DEPTH must be at least 2");
  end

  state_t               r_state;
  logic [ADDR_W-1:0]    r_cnt;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_rv1;

  logic                 w_accept;
  logic                 w_clearing;
  logic                 w_arr_we;
  logic                 w_arr_re;
  logic [ADDR_W-1:0]    w_arr_addr;
  logic [WORD_SIZE-1:0] w_arr_wdata;
  logic [BE_W-1:0]      w_arr_be;
  logic [WORD_SIZE-1:0] w_arr_rdata;

  // A clr in IDLE wins over a simultaneous req: that req is not taken.
  assign w_accept   = bus.req & r_ready & ~bus.clr;
  assign w_clearing = (r_state == ST_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_ready <= (CLEAR_ON_RESET == 0);
      r_busy  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clr is ignored here; the sweep never restarts mid-way.
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Clear sweep borrows the write port with all lanes enabled.
  assign w_arr_we    = w_clearing | (w_accept & bus.we);
  assign w_arr_re    = w_accept & ~bus.we;
  assign w_arr_addr  = w_clearing ? r_cnt : bus.addr;
  assign w_arr_wdata = w_clearing ? '0 : bus.wdata;
  assign w_arr_be    = w_clearing ? '1 : bus.be;

  param_ram_array #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .i_be    (w_arr_be),
    .o_rdata (w_arr_rdata)
  );

  // Read pipeline runs independently of the FSM so reads already in flight
  // when a clear starts still deliver their pre-clear data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rv1 <= 1'b0;
    end else begin
      r_rv1 <= w_arr_re;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WORD_SIZE-1:0] r_rdata_q;
    logic                 r_rv2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rdata_q <= '0;
        r_rv2     <= 1'b0;
      end else begin
        r_rv2 <= r_rv1;
        if (r_rv1) begin
          r_rdata_q <= w_arr_rdata;
        end
      end
    end

    assign bus.rdata  = r_rdata_q;
    assign bus.rvalid = r_rv2;
  end else begin : g_no_out_reg
    assign bus.rdata  = w_arr_rdata;
    assign bus.rvalid = r_rv1;
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_param_ram.sv
module tb_param_ram;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;

  int n_checks = 0;
  int n_err    = 0;

  // A: 32-bit words, 32 deep, no output register.
  // B: 8-bit words, 20 deep, output register.
  param_ram_if #(.WORD_SIZE(32), .DEPTH(32)) bus_a ();
  param_ram_if #(.WORD_SIZE(8),  .DEPTH(20)) bus_b ();

  param_ram #(
    .WORD_SIZE(32), .DEPTH(32), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a)
  );

  param_ram #(
    .WORD_SIZE(8), .DEPTH(20), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic count_busy_a(output int n);
    n = 0;
    while (bus_a.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    while (bus_b.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 4'b1111, 32'h0};
    vecs[1]  = '{1'b1, 5'd5,  32'h00001122, 4'b0011, 32'h0};
    vecs[2]  = '{1'b0, 5'd5,  32'h0,        4'b0000, 32'hDEAD1122};
    vecs[3]  = '{1'b1, 5'd7,  32'h000000AA, 4'b0001, 32'h0};
    vecs[4]  = '{1'b0, 5'd7,  32'h0,        4'b0000, 32'h000000AA};
    vecs[5]  = '{1'b1, 5'd9,  32'hFFFFFFFF, 4'b0000, 32'h0};
    vecs[6]  = '{1'b0, 5'd9,  32'h0,        4'b0000, 32'h00000000};
    vecs[7]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 4'b1010, 32'h0};
    vecs[8]  = '{1'b0, 5'd31, 32'h0,        4'b0000, 32'hA500A500};
    vecs[9]  = '{1'b1, 5'd0,  32'h12345678, 4'b0100, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        4'b0000, 32'h00340000};

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.clr = 1'b0; bus_a.req = 1'b0; bus_a.we = 1'b0;
    bus_a.addr = '0;  bus_a.wdata = '0; bus_a.be = '0;
    bus_b.clr = 1'b0; bus_b.req = 1'b0; bus_b.we = 1'b0;
    bus_b.addr = '0;  bus_b.wdata = '0; bus_b.be = '0;

    repeat (2) @(negedge clk);
    check("a_reset_rvalid", 32'(bus_a.rvalid), 32'd0);
    check("a_reset_rdata",  bus_a.rdata,       32'd0);
    check("a_reset_busy",   32'(bus_a.busy),   32'd1);
    check("a_reset_ready",  32'(bus_a.ready),  32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Power-up clear: busy for exactly DEPTH cycles.
    count_busy_a(n);
    check("a_init_clear_cycles", 32'(n), 32'd32);
    check("a_ready_after_clear", 32'(bus_a.ready), 32'd1);

    // Read every address back-to-back: all zero, rvalid one cycle later.
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) begin
        check("a_clear_rvalid", 32'(bus_a.rvalid), 32'd1);
        check("a_clear_rdata",  bus_a.rdata,       32'd0);
      end
      if (i < 32) begin
        bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 5'(i);
      end else begin
        bus_a.req = 1'b0;
      end
      @(negedge clk);
    end

    // Table of single transactions.
    for (int i = 0; i < 11; i++) begin
      bus_a.req = 1'b1; bus_a.we = vecs[i].we; bus_a.addr = vecs[i].addr;
      bus_a.wdata = vecs[i].wdata; bus_a.be = vecs[i].be;
      @(negedge clk);
      bus_a.req = 1'b0;
      if (vecs[i].we) begin
        check("a_vec_write_no_rvalid", 32'(bus_a.rvalid), 32'd0);
      end else begin
        check("a_vec_rvalid", 32'(bus_a.rvalid), 32'd1);
        check("a_vec_rdata",  bus_a.rdata,       vecs[i].exp);
      end
      @(negedge clk);
    end

    // Read 7 then write 7 next cycle: read sees old data; later read sees new.
    bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 5'd7;
    @(negedge clk);
    check("a_hz_rvalid_old", 32'(bus_a.rvalid), 32'd1);
    check("a_hz_rdata_old",  bus_a.rdata,       32'h000000AA);
    bus_a.we = 1'b1; bus_a.wdata = 32'h00000055; bus_a.be = 4'b1111;
    @(negedge clk);
    check("a_hz_write_no_rvalid", 32'(bus_a.rvalid), 32'd0);
    bus_a.we = 1'b0;
    @(negedge clk);
    bus_a.req = 1'b0;
    check("a_hz_rvalid_new", 32'(bus_a.rvalid), 32'd1);
    check("a_hz_rdata_new",  bus_a.rdata,       32'h00000055);
    @(negedge clk);

    // clr together with a read: read not taken, second clr mid-way ignored.
    bus_a.clr = 1'b1; bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 5'd7;
    @(negedge clk);
    bus_a.clr = 1'b0; bus_a.req = 1'b0;
    check("a_clr_beats_req", 32'(bus_a.rvalid), 32'd0);
    n = 0;
    while (bus_a.busy && n < 200) begin
      n++;
      bus_a.clr = (n == 10);
      @(negedge clk);
    end
    bus_a.clr = 1'b0;
    check("a_clr_cycles_with_reclr", 32'(n), 32'd32);
    check("a_ready_after_clr", 32'(bus_a.ready), 32'd1);

    // Reset during a read: the pending rvalid and its data are flushed.
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 5'd5;
    bus_a.wdata = 32'h12345678; bus_a.be = 4'b1111;
    @(negedge clk);
    bus_a.we = 1'b0;
    @(posedge clk);
    #2 rst_n_a = 1'b0;
    @(negedge clk);
    bus_a.req = 1'b0;
    check("a_rst_mid_read_rvalid", 32'(bus_a.rvalid), 32'd0);
    check("a_rst_mid_read_rdata",  bus_a.rdata,       32'd0);
    rst_n_a = 1'b1;
    count_busy_a(n);
    check("a_rst_clear_cycles", 32'(n), 32'd32);
    bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 5'd5;
    @(negedge clk);
    bus_a.req = 1'b0;
    check("a_cleared_rdata", bus_a.rdata, 32'd0);

    // Reset in the middle of a clear restarts the full sweep.
    bus_a.clr = 1'b1;
    @(negedge clk);
    bus_a.clr = 1'b0;
    repeat (14) @(negedge clk);
    rst_n_a = 1'b0;
    #1;
    check("a_rst_mid_clear_rvalid", 32'(bus_a.rvalid), 32'd0);
    check("a_rst_mid_clear_busy",   32'(bus_a.busy),   32'd1);
    @(negedge clk);
    rst_n_a = 1'b1;
    count_busy_a(n);
    check("a_restart_clear_cycles", 32'(n), 32'd32);

    // ---- DUT B: OUT_REG = 1, DEPTH = 20 ----
    n = 0;
    while (!bus_b.ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("b_ready", 32'(bus_b.ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      bus_b.req = 1'b1; bus_b.we = 1'b1; bus_b.addr = 5'(i);
      bus_b.wdata = 8'(8'h10 + i); bus_b.be = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.addr = 5'(i);
      end else begin
        bus_b.req = 1'b0;
      end
      @(negedge clk);
      if (i >= 1 && i <= 4) begin
        check("b_b2b_rvalid", 32'(bus_b.rvalid), 32'd1);
        check("b_b2b_rdata",  32'(bus_b.rdata),  32'(8'h0F + i));
      end else begin
        check("b_b2b_rvalid_idle", 32'(bus_b.rvalid), 32'd0);
      end
    end

    // Out-of-range write dropped, out-of-range read returns 0 on time.
    bus_b.req = 1'b1; bus_b.we = 1'b1; bus_b.addr = 5'd19; bus_b.wdata = 8'h77;
    @(negedge clk);
    bus_b.addr = 5'd25; bus_b.wdata = 8'hFF;
    @(negedge clk);
    bus_b.we = 1'b0;
    @(negedge clk);
    bus_b.addr = 5'd19;
    @(negedge clk);
    bus_b.req = 1'b0;
    check("b_oor_rvalid", 32'(bus_b.rvalid), 32'd1);
    check("b_oor_rdata",  32'(bus_b.rdata),  32'd0);
    @(negedge clk);
    check("b_19_rvalid", 32'(bus_b.rvalid), 32'd1);
    check("b_19_rdata",  32'(bus_b.rdata),  32'h77);
    @(negedge clk);

    // Read in flight when clr is accepted returns pre-clear data.
    bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.addr = 5'd19;
    @(negedge clk);
    bus_b.req = 1'b0; bus_b.clr = 1'b1;
    @(negedge clk);
    bus_b.clr = 1'b0;
    check("b_inflight_rvalid", 32'(bus_b.rvalid), 32'd1);
    check("b_inflight_rdata",  32'(bus_b.rdata),  32'h77);
    count_busy_b(n);
    check("b_clear_cycles", 32'(n), 32'd20);
    bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.addr = 5'd19;
    @(negedge clk);
    bus_b.req = 1'b0;
    @(negedge clk);
    check("b_post_clear_rvalid", 32'(bus_b.rvalid), 32'd1);
    check("b_post_clear_rdata",  32'(bus_b.rdata),  32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
